// File: rtl/branch_resolve_queue_if.sv
// Branch resolve queue bus: fetch-side allocation, execute-side resolution,
// and the flush/redirect/predictor-update results.
//   master : fetch/execute side (drives alloc_* and res_*)
//   slave  : the queue itself (drives alloc_ready, flush, redirect_pc,
//            upd_*, count, mispredict_cnt)
interface branch_resolve_queue_if;
    logic       alloc_valid;
    logic [9:0] alloc_pc;
    logic [9:0] alloc_target;
    logic       alloc_pred;
    logic       alloc_ready;
    logic       res_valid;
    logic       res_taken;
    logic       flush;
    logic [9:0] redirect_pc;
    logic       upd_we;
    logic [9:0] upd_pc;
    logic       upd_taken;
    logic [3:0] count;
    logic [7:0] mispredict_cnt;

    modport master (
        output alloc_valid, alloc_pc, alloc_target, alloc_pred,
        output res_valid, res_taken,
        input  alloc_ready, flush, redirect_pc, upd_we, upd_pc, upd_taken,
        input  count, mispredict_cnt
    );

    modport slave (
        input  alloc_valid, alloc_pc, alloc_target, alloc_pred,
        input  res_valid, res_taken,
        output alloc_ready, flush, redirect_pc, upd_we, upd_pc, upd_taken,
        output count, mispredict_cnt
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: holds in-flight predicted branches in issue order,
// resolves the oldest against the actual outcome, writes the outcome back to
// the predictor and raises a one-cycle flush with the corrected pc on a
// mispredict (discarding all younger branches).
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous reset, active low
//   bus   - branch_resolve_queue_if.slave (alloc/resolve in, flush/update out)
module branch_resolve_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    branch_resolve_queue_if.slave   bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PCW = 10;

    typedef struct packed {
        logic [PCW-1:0] pc;
        logic [PCW-1:0] target;
        logic           pred;
    } entry_t;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    state_t         state;
    entry_t         mem [DEPTH];
    logic [AW-1:0]  head;
    logic [AW-1:0]  tail;
    logic [3:0]     count;
    logic           flush;
    logic [PCW-1:0] redirect_pc;
    logic           upd_we;
    logic [PCW-1:0] upd_pc;
    logic           upd_taken;
    logic [7:0]     mispredict_cnt;

    logic           ready;
    logic           alloc_fire;
    logic           res_fire;
    logic           mispredict;
    entry_t         head_entry;
    entry_t         new_entry;

    // Readiness uses only the registered count: a same-cycle pop never frees a slot.
    assign ready      = (state == RUN) && (count < 4'(DEPTH));
    assign alloc_fire = bus.alloc_valid && ready;
    assign res_fire   = bus.res_valid && (state == RUN) && (count != 4'd0);
    assign head_entry = mem[head];
    assign mispredict = res_fire && (bus.res_taken != head_entry.pred);
    assign new_entry  = '{pc: bus.alloc_pc, target: bus.alloc_target, pred: bus.alloc_pred};

    // Entry storage; a dropped allocation may write a slot but never advances tail.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            mem[tail] <= new_entry;
        end
    end

    // Pointers, occupancy, FSM and registered result pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= RUN;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            flush          <= 1'b0;
            redirect_pc    <= '0;
            upd_we         <= 1'b0;
            upd_pc         <= '0;
            upd_taken      <= 1'b0;
            mispredict_cnt <= '0;
        end else begin
            flush  <= 1'b0;
            upd_we <= 1'b0;

            if (res_fire) begin
                upd_we    <= 1'b1;
                upd_pc    <= head_entry.pc;
                upd_taken <= bus.res_taken;
            end

            case (state)
                RUN: begin
                    if (mispredict) begin
                        // Discard everything, including any same-cycle allocation.
                        flush       <= 1'b1;
                        redirect_pc <= bus.res_taken ? head_entry.target
                                                     : PCW'(head_entry.pc + PCW'(1));
                        if (mispredict_cnt != 8'hFF) begin
                            mispredict_cnt <= mispredict_cnt + 8'd1;
                        end
                        head  <= tail;
                        count <= '0;
                        state <= SQUASH;
                    end else begin
                        if (alloc_fire) begin
                            tail <= tail + AW'(1);
                        end
                        if (res_fire) begin
                            head <= head + AW'(1);
                        end
                        count <= count + 4'(alloc_fire) - 4'(res_fire);
                    end
                end
                SQUASH: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    assign bus.alloc_ready    = ready;
    assign bus.flush          = flush;
    assign bus.redirect_pc    = redirect_pc;
    assign bus.upd_we         = upd_we;
    assign bus.upd_pc         = upd_pc;
    assign bus.upd_taken      = upd_taken;
    assign bus.count          = count;
    assign bus.mispredict_cnt = mispredict_cnt;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: directed scenarios plus a
// randomized phase, checked by a queue-based reference model and a scoreboard
// of expected predictor-update/flush results popped by an independent monitor.
module tb_branch_resolve_queue;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [9:0] pc;
        logic [9:0] target;
        logic       pred;
    } br_t;

    typedef struct {
        logic [9:0] pc;
        logic       taken;
        logic       flush;
        logic [9:0] redirect;
    } upd_t;

    logic clk;
    logic rst;

    branch_resolve_queue_if bus ();

    branch_resolve_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state
    br_t  mq[$];
    upd_t sb[$];
    bit   m_squash = 1'b0;
    int   m_mcnt = 0;
    logic [9:0] m_redirect = '0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // One cycle of stimulus; the model is advanced with the same inputs.
    task automatic step(input logic av, input logic [9:0] pc, input logic [9:0] tgt,
                        input logic pr, input logic rv, input logic rt);
        bit   exp_ready;
        bit   fire_res;
        bit   fire_alloc;
        br_t  e;
        upd_t x;
        @(negedge clk);
        bus.alloc_valid  = av;
        bus.alloc_pc     = pc;
        bus.alloc_target = tgt;
        bus.alloc_pred   = pr;
        bus.res_valid    = rv;
        bus.res_taken    = rt;
        exp_ready = !m_squash && (mq.size() < DEPTH);
        check("alloc_ready", 32'(bus.alloc_ready), 32'(exp_ready));
        fire_res   = rv && !m_squash && (mq.size() != 0);
        fire_alloc = av && exp_ready;
        m_squash   = 1'b0;
        if (fire_res) begin
            e = mq.pop_front();
            x.pc       = e.pc;
            x.taken    = rt;
            x.flush    = (rt != e.pred);
            x.redirect = rt ? e.target : 10'(e.pc + 10'd1);
            sb.push_back(x);
            if (x.flush) begin
                mq.delete();
                m_squash   = 1'b1;
                m_redirect = x.redirect;
                if (m_mcnt < 255) m_mcnt++;
                fire_alloc = 1'b0;
            end
        end
        if (fire_alloc) begin
            e.pc = pc; e.target = tgt; e.pred = pr;
            mq.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset pulse asserted mid-cycle with traffic pending.
    task automatic do_reset_midway();
        @(negedge clk);
        bus.alloc_valid = 1'b1;
        bus.alloc_pc    = 10'h222;
        bus.res_valid   = 1'b1;
        bus.res_taken   = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_flush",   32'(bus.flush), 32'd0);
        check("rst_upd_we",  32'(bus.upd_we), 32'd0);
        check("rst_upd_pc",  32'(bus.upd_pc), 32'd0);
        check("rst_upd_tk",  32'(bus.upd_taken), 32'd0);
        check("rst_count",   32'(bus.count), 32'd0);
        check("rst_redir",   32'(bus.redirect_pc), 32'd0);
        check("rst_mcnt",    32'(bus.mispredict_cnt), 32'd0);
        mq.delete();
        sb.delete();
        m_squash = 1'b0; m_mcnt = 0; m_redirect = '0;
        bus.alloc_valid = 1'b0;
        bus.res_valid   = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: compares DUT results against the scoreboard after each edge.
    initial begin
        upd_t x;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                if (bus.upd_we) begin
                    if (sb.size() == 0) begin
                        check("spurious_upd_we", 32'(bus.upd_we), 32'd0);
                    end else begin
                        x = sb.pop_front();
                        check("upd_pc",    32'(bus.upd_pc), 32'(x.pc));
                        check("upd_taken", 32'(bus.upd_taken), 32'(x.taken));
                        check("flush",     32'(bus.flush), 32'(x.flush));
                    end
                end else begin
                    check("flush_no_upd", 32'(bus.flush), 32'd0);
                    if (sb.size() != 0) begin
                        x = sb.pop_front();
                        check("missing_upd_we", 32'(bus.upd_we), 32'd1);
                    end
                end
                check("redirect_pc",    32'(bus.redirect_pc), 32'(m_redirect));
                check("count",          32'(bus.count), 32'(mq.size()));
                check("mispredict_cnt", 32'(bus.mispredict_cnt), 32'(m_mcnt));
            end
        end
    end

    initial begin
        bit rt;
        bus.alloc_valid = 1'b0; bus.alloc_pc = '0; bus.alloc_target = '0;
        bus.alloc_pred = 1'b0; bus.res_valid = 1'b0; bus.res_taken = 1'b0;
        rst = 1'b0;
        #1;
        check("init_upd_we", 32'(bus.upd_we), 32'd0);
        check("init_count",  32'(bus.count), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Correct taken prediction
        step(1'b1, 10'h010, 10'h020, 1'b1, 1'b0, 1'b0);
        step(1'b0, 10'h000, 10'h000, 1'b0, 1'b1, 1'b1);
        idle(2);

        // Not-taken mispredict at top of pc space: redirect wraps to 0
        step(1'b1, 10'h3FF, 10'h100, 1'b1, 1'b0, 1'b0);
        step(1'b0, 10'h000, 10'h000, 1'b0, 1'b1, 1'b0);
        idle(3);

        // Fill, alloc blocked while full, continue through pointer wrap
        for (int i = 0; i < 4; i++) step(1'b1, 10'(10'h040 + i), 10'h0AA, 1'(i), 1'b0, 1'b0);
        step(1'b1, 10'h0FF, 10'h0BB, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 10'(10'h080 + i), 10'h0CC, 1'(i + 1), 1'b1, mq[0].pred);
        for (int i = 0; i < 4; i++) step(1'b0, 10'h0, 10'h0, 1'b0, 1'b1, mq.size() != 0 ? mq[0].pred : 1'b0);
        idle(2);

        // Middle entry mispredicts taken with same-cycle allocation
        step(1'b1, 10'h100, 10'h111, 1'b1, 1'b0, 1'b0);
        step(1'b1, 10'h101, 10'h155, 1'b0, 1'b0, 1'b0);
        step(1'b1, 10'h102, 10'h177, 1'b1, 1'b0, 1'b0);
        step(1'b0, 10'h000, 10'h000, 1'b0, 1'b1, 1'b1);
        step(1'b1, 10'h1EE, 10'h1EF, 1'b1, 1'b1, 1'b1);
        step(1'b0, 10'h000, 10'h000, 1'b0, 1'b1, 1'b1);
        step(1'b0, 10'h000, 10'h000, 1'b0, 1'b1, 1'b1);
        idle(2);

        // Resolution on an empty queue, including with same-cycle allocation
        step(1'b0, 10'h000, 10'h000, 1'b0, 1'b1, 1'b1);
        step(1'b1, 10'h033, 10'h044, 1'b1, 1'b1, 1'b0);
        step(1'b0, 10'h000, 10'h000, 1'b0, 1'b1, 1'b1);
        idle(2);

        // Saturation of the mispredict counter
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 10'($urandom), 10'($urandom), 1'b1, 1'b0, 1'b0);
            step(1'b0, 10'h000, 10'h000, 1'b0, 1'b1, 1'b0);
        end
        idle(2);

        // Reset with two entries queued and a resolution pending
        step(1'b1, 10'h201, 10'h301, 1'b1, 1'b0, 1'b0);
        step(1'b1, 10'h202, 10'h302, 1'b0, 1'b0, 1'b0);
        do_reset_midway();
        idle(4);

        // Randomized traffic, mostly correct predictions
        for (int i = 0; i < 3000; i++) begin
            rt = (mq.size() != 0 && $urandom_range(9) < 8) ? mq[0].pred : 1'($urandom);
            step(1'($urandom_range(3) != 0), 10'($urandom), 10'($urandom), 1'($urandom),
                 1'($urandom_range(1)), rt);
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/branch_resolve_queue.md
BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of in-flight branch entries (power of two, 2..8).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 alloc_valid  input  1  fetch issues a predicted branch this cycle.
REQ-005 alloc_pc  input  10  pc of the issued branch.
REQ-006 alloc_target  input  10  branch target address.
REQ-007 alloc_pred  input  1  predictor output for the branch: 1 means taken.
REQ-008 alloc_ready  output  1  queue can accept an allocation this cycle.
REQ-009 res_valid  input  1  execute resolves the oldest outstanding branch.
REQ-010 res_taken  input  1  actual branch outcome.
REQ-011 flush  output  1  one-cycle misprediction pulse to the pipeline.
REQ-012 redirect_pc  output  10  corrected fetch pc, valid when flush=1.
REQ-013 upd_we  output  1  predictor table write enable.
REQ-014 upd_pc  output  10  pc of the branch being written back to the predictor.
REQ-015 upd_taken  output  1  outcome written back to the predictor.
REQ-016 count  output  4  current number of valid entries.
REQ-017 mispredict_cnt  output  8  saturating count of mispredictions since reset.

Function
REQ-018 Storage: circular FIFO of DEPTH entries {pc, target, pred}, with head and tail pointers wrapping modulo DEPTH.
REQ-019 FSM states RUN and SQUASH; reset state RUN.
REQ-020 alloc_ready = (state==RUN) && (count<DEPTH), computed from the current registered count only, so a same-cycle pop does not free a slot.
REQ-021 Allocation fires when alloc_valid && alloc_ready: write entry at tail, tail+1.
REQ-022 Resolution fires when res_valid && state==RUN && count!=0: read entry at head, head+1.
REQ-023 res_valid with count==0, or in SQUASH, is ignored with no output effect.
REQ-024 An entry allocated in cycle N is resolvable from cycle N+1; resolution at N with count==0 is ignored even if alloc fires at N.
REQ-025 Simultaneous allocation and non-mispredicting resolution: both take effect and count is unchanged.
REQ-026 Outputs are registered: a resolution in cycle N drives upd_we=1, upd_pc=entry.pc, upd_taken=res_taken during cycle N+1 only.
REQ-027 Mispredict when res_taken != entry.pred.
REQ-028 On mispredict, during cycle N+1: flush=1; redirect_pc = entry.target if res_taken, else entry.pc+1 (10-bit, 0x3FF+1 wraps to 0x000).
REQ-029 On mispredict: all entries are discarded (count=0, head=tail) at the cycle N edge, any same-cycle allocation is dropped, and state goes to SQUASH.
REQ-030 SQUASH lasts exactly one cycle (alloc_ready=0), then returns to RUN.
REQ-031 mispredict_cnt increments by 1 per mispredict and holds at 255.
REQ-032 flush, upd_we and redirect_pc updates are one-cycle pulses; redirect_pc holds its last value when flush=0.

Reset
REQ-033 rst=0 asynchronously forces state=RUN, head=tail=0, count=0, flush=0, upd_we=0, upd_pc=0, upd_taken=0, redirect_pc=0, mispredict_cnt=0; entry storage need not be cleared.
REQ-034 Reset asserted mid-operation discards all in-flight entries; no update or flush pulse is emitted for them after rst returns to 1.
REQ-035 alloc_ready=1 in the first cycle after reset release.

Verification
REQ-036 Alloc pc=0x010, tgt=0x020, pred=1; next cycle res_taken=1 -> cycle after: upd_we=1, upd_pc=0x010, upd_taken=1, flush=0, count=0.
REQ-037 Alloc pc=0x3FF, pred=1; resolve res_taken=0 -> flush=1, redirect_pc=0x000, mispredict_cnt=1, count=0, alloc_ready=0 for one cycle, then 1.
REQ-038 Alloc 4 branches (DEPTH=4) -> count=4, alloc_ready=0; alloc+resolve in the same cycle -> pop only, count=3; allocations continue through pointer wrap-around in order.
REQ-039 3 entries queued, middle entry mispredicts (pred=0, taken=1, tgt=0x155) with alloc_valid same cycle -> flush=1, redirect_pc=0x155, count=0, third entry and new alloc never produce upd_we.
REQ-040 res_valid with empty queue -> no upd_we, no flush; 300 consecutive mispredicts -> mispredict_cnt=255.
REQ-041 rst pulsed low with 2 entries queued and a resolution pending -> all outputs at reset values immediately, count=0, no upd_we after release.
